// File: rtl/clock_period_meter.sv
// clock_period_meter: measures sig_in rise-to-rise period in clock cycles with stall timeout.
// Optional high_time output enabled by defining CLOCK_PERIOD_METER_HIGH_TIME_EN.
module clock_period_meter #(
  parameter int CNT_W       = 26,
  parameter int TIMEOUT     = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             timeout,
  output logic             armed
`ifdef CLOCK_PERIOD_METER_HIGH_TIME_EN
  ,
  output logic [CNT_W-1:0] high_time
`endif
);
  typedef enum logic {IDLE, MEASURE} state_t;
  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic                   sync_out;
  logic                   rise;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_inc;
  always_comb begin
    sync_out = sync[SYNC_STAGES-1];
    rise     = sync_out & ~hist;
    cnt_inc  = cnt + CNT_W'(1);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sync         <= '0;
      hist         <= 1'b0;
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      armed        <= 1'b0;
    end else begin
      sync         <= {sync[SYNC_STAGES-2:0], sig_in};
      hist         <= sync_out;
      period_valid <= 1'b0;
      if (state == IDLE) begin
        cnt <= '0;
        if (rise) begin
          state <= MEASURE;
          armed <= 1'b1;
        end
      end else if (rise) begin
        period       <= cnt_inc;
        period_valid <= 1'b1;
        timeout      <= 1'b0;
        cnt          <= '0;
      end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
        timeout <= 1'b1;
        cnt     <= '0;
        state   <= IDLE;
        armed   <= 1'b0;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end
`ifdef CLOCK_PERIOD_METER_HIGH_TIME_EN
  logic [CNT_W-1:0] hcnt;
  // The rise cycle itself is the first high cycle of the new period.
  always_ff @(posedge clock) begin
    if (reset) begin
      hcnt      <= '0;
      high_time <= '0;
    end else if (rise) begin
      hcnt <= CNT_W'(1);
      if (state == MEASURE) high_time <= hcnt;
    end else if (sync_out && !(&hcnt)) begin
      hcnt <= hcnt + CNT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter: directed and random checks of clock_period_meter against an event-level model.
module tb_clock_period_meter;
  localparam int CNT_W = 16, TIMEOUT = 100;
  logic clk = 1'b0, reset = 1'b1, sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic period_valid, timeout, armed;
`ifdef CLOCK_PERIOD_METER_HIGH_TIME_EN
  logic [CNT_W-1:0] high_time;
`endif
  int errors = 0, checks = 0, now = 0, hrun = 0, m_last = 0, arm_t = 0, disarm_t = 0;
  bit m_armed = 0, armed_q = 0, pv_prev = 0;
  int exp_p[$], exp_h[$], obs_p[$], obs_h[$];

  clock_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
    .clock(clk), .reset(reset), .sig_in(sig_in), .period(period),
    .period_valid(period_valid), .timeout(timeout), .armed(armed)
`ifdef CLOCK_PERIOD_METER_HIGH_TIME_EN
    , .high_time(high_time)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint o, input longint e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  // Model works on input rise times: a gap up to TIMEOUT is a measurement, a longer one re-arms.
  task automatic step(input logic v);
    @(posedge clk);
    #1;
    if (v && !sig_in) begin
      if (m_armed && now - m_last <= TIMEOUT) begin
        exp_p.push_back(now - m_last);
        exp_h.push_back(hrun);
      end
      m_armed = 1;
      m_last  = now;
      hrun    = 0;
    end
    if (v) hrun++;
    sig_in = v;
    now++;
    @(negedge clk);
    if (armed && !armed_q) arm_t = now;
    if (!armed && armed_q) disarm_t = now;
    armed_q = armed;
  endtask

  task automatic seg(input int h, input int l);
    repeat (h) step(1'b1);
    repeat (l) step(1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0);
    step(1'b0);
    reset   = 1'b0;
    m_armed = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_valid"}, period_valid, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_armed"}, armed, 0);
  endtask

  task automatic check_events(input string tag);
    repeat (8) step(1'b0);
    chk({tag, "_count"}, obs_p.size(), exp_p.size());
    for (int i = 0; i < obs_p.size() && i < exp_p.size(); i++) begin
      chk({tag, "_period"}, obs_p[i], exp_p[i]);
`ifdef CLOCK_PERIOD_METER_HIGH_TIME_EN
      chk({tag, "_high"}, obs_h[i], exp_h[i]);
`endif
    end
    exp_p.delete(); exp_h.delete(); obs_p.delete(); obs_h.delete();
  endtask

  always @(negedge clk) begin
    if (period_valid) begin
      obs_p.push_back(int'(period));
`ifdef CLOCK_PERIOD_METER_HIGH_TIME_EN
      obs_h.push_back(int'(high_time));
`endif
      chk("valid_consecutive", pv_prev, 0);
      chk("timeout_on_valid", timeout, 0);
    end
    pv_prev = period_valid;
  end

  initial begin
    int h, l;
    do_reset();
    chk_zero("reset");
    repeat (6) seg(5, 5);
    check_events("sq10");
    chk("sq10_timeout", timeout, 0);
    repeat (150) step(1'b0);
    chk("stall_timeout", timeout, 1);
    chk("stall_armed", armed, 0);
    seg(5, 150);
    chk("timeout_delay", disarm_t - arm_t, TIMEOUT);
    chk("rearm_timeout", timeout, 1);
    chk("rearm_armed", armed, 0);
    chk("timeout_period_held", period, 10);
    check_events("stall");
    seg(10, 10);
    seg(10, 10);
    check_events("p20");
    chk("p20_timeout_cleared", timeout, 0);
    seg(5, 5);
    seg(5, 1);
    do_reset();
    chk_zero("mid_reset");
    check_events("pre_reset");
    repeat (3) seg(5, 5);
    check_events("post_reset");
    seg(50, 50);
    seg(50, 51);
    seg(5, 5);
    seg(5, 5);
    check_events("boundary");
    chk("boundary_timeout", timeout, 0);
    repeat (4) seg(3, 7);
    check_events("h3l7");
    repeat (40) begin
      h = int'($urandom_range(1, 8));
      l = ($urandom_range(0, 7) == 0) ? int'($urandom_range(90, 110)) : int'($urandom_range(1, 8));
      seg(h, l);
    end
    check_events("random");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
